// File: rtl/uart_frame_pkg.sv
// Shared frame constants and FSM state type for the VGA serial display path
// (used by both the frame writer and the RAM reader).
package uart_frame_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   localparam int FRAME_WIDTH       = 480;
   localparam int FRAME_HEIGHT      = 360;
   localparam int BITS_PER_PIXEL    = 24;
   localparam int DEFAULT_RAM_WIDTH = 32;
   localparam int DEFAULT_N_BITS    = FRAME_WIDTH * FRAME_HEIGHT * BITS_PER_PIXEL;

endpackage

// File: rtl/uart_frame_writer_packer.sv
// rx_word_packer: big-endian byte-to-word accumulator with a combinational
// word_ready strobe raised on the byte that completes a word.
module rx_word_packer #(
   parameter int RAM_WIDTH = 32,
   localparam int BYTES_PER_WORD = RAM_WIDTH / 8,
   localparam int IDX_BITS = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 word_ready,
   output logic [RAM_WIDTH-1:0] full_word
);

   logic [IDX_BITS-1:0]  idx_reg;
   logic [RAM_WIDTH-1:0] acc_reg;

   // Stale bytes need no clearing: a full word shifts every old byte out.
   assign full_word  = (acc_reg << 8) | RAM_WIDTH'(rx_data);
   assign word_ready = rx_valid && (idx_reg == IDX_BITS'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg <= '0;
         acc_reg <= '0;
      end else if (clear) begin
         idx_reg <= '0;
      end else if (rx_valid) begin
         acc_reg <= full_word;
         idx_reg <= word_ready ? '0 : idx_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_frame_writer.sv
// Packs UART bytes into RAM words and writes a frame at sequential addresses.
// Optional idle-timeout resync is built when UART_FRAME_WRITER_TIMEOUT_EN is defined.
module uart_frame_writer
   import uart_frame_pkg::*;
#(
   parameter int RAM_WIDTH      = DEFAULT_RAM_WIDTH,
   parameter int N_BITS         = DEFAULT_N_BITS,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   localparam int BYTES_PER_WORD = RAM_WIDTH / 8,
   localparam int RAM_DEPTH      = N_BITS / RAM_WIDTH,
   localparam int MAX_ADDRESS    = RAM_DEPTH - 1,
   localparam int ADDRESS_BITS   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    wr_en,
   output logic [ADDRESS_BITS-1:0] wr_addr,
   output logic [RAM_WIDTH-1:0]    wr_data,
   output logic                    frame_done,
   output logic                    timeout_err,
   output logic                    busy
);

   if ((RAM_WIDTH % 8) != 0 || RAM_WIDTH < 8) begin : g_bad_width
      $error("RAM_WIDTH must be a non-zero multiple of 8");
   end
   if ((N_BITS % RAM_WIDTH) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_frame
      $error("N_BITS must be a multiple of RAM_WIDTH and TIMEOUT_CYCLES >= 1");
   end

   state_t                  state_reg, state_next;
   logic [ADDRESS_BITS-1:0] addr_reg, addr_next;
   logic                    wr_en_reg, wr_en_next;
   logic [ADDRESS_BITS-1:0] wr_addr_reg, wr_addr_next;
   logic [RAM_WIDTH-1:0]    wr_data_reg, wr_data_next;
   logic                    frame_done_reg, frame_done_next;
   logic                    timeout_err_reg, timeout_err_next;
   logic                    packer_clear;
   logic                    word_ready;
   logic [RAM_WIDTH-1:0]    full_word;
   logic                    timeout_hit;

   rx_word_packer #(
      .RAM_WIDTH (RAM_WIDTH)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (packer_clear),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .word_ready (word_ready),
      .full_word  (full_word)
   );

`ifdef UART_FRAME_WRITER_TIMEOUT_EN
   localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_BITS-1:0] idle_cnt_reg;

   // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of a frame.
   assign timeout_hit = (state_reg == COLLECT) && !rx_valid &&
                        (idle_cnt_reg == CNT_BITS'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || state_reg != COLLECT || rx_valid || timeout_hit)
         idle_cnt_reg <= '0;
      else
         idle_cnt_reg <= idle_cnt_reg + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_next       = state_reg;
      addr_next        = addr_reg;
      wr_en_next       = 1'b0;
      wr_addr_next     = wr_addr_reg;
      wr_data_next     = wr_data_reg;
      frame_done_next  = 1'b0;
      timeout_err_next = 1'b0;
      packer_clear     = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (rx_valid)
               state_next = COLLECT;
         end
         COLLECT: begin
            if (timeout_hit) begin
               addr_next        = '0;
               packer_clear     = 1'b1;
               timeout_err_next = 1'b1;
               state_next       = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // Word completion can only coincide with rx_valid, never with a timeout.
      if (word_ready) begin
         wr_en_next   = 1'b1;
         wr_addr_next = addr_reg;
         wr_data_next = full_word;
         if (addr_reg == ADDRESS_BITS'(MAX_ADDRESS)) begin
            addr_next       = '0;
            frame_done_next = 1'b1;
            state_next      = IDLE;
         end else begin
            addr_next = addr_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         addr_reg        <= '0;
         wr_en_reg       <= 1'b0;
         wr_addr_reg     <= '0;
         wr_data_reg     <= '0;
         frame_done_reg  <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         addr_reg        <= addr_next;
         wr_en_reg       <= wr_en_next;
         wr_addr_reg     <= wr_addr_next;
         wr_data_reg     <= wr_data_next;
         frame_done_reg  <= frame_done_next;
         timeout_err_reg <= timeout_err_next;
      end
   end

   assign wr_en       = wr_en_reg;
   assign wr_addr     = wr_addr_reg;
   assign wr_data     = wr_data_reg;
   assign frame_done  = frame_done_reg;
   assign timeout_err = timeout_err_reg;
   assign busy        = (state_reg == COLLECT);

endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed bench for uart_frame_writer: 4-word frame of 32-bit words, 20-cycle timeout.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_uart_frame_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic        frame_done;
   logic        timeout_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_frame_writer #(
      .RAM_WIDTH      (32),
      .N_BITS         (128),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_done  (frame_done),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs for one clock; returns at the next falling edge.
   task automatic step(input logic v, input logic [7:0] d);
      rx_valid = v;
      rx_data  = d;
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic chk_write(input string tag, input logic [1:0] a, input logic [31:0] d,
                            input logic fd);
      chk({tag, "_wr_en"}, wr_en, 1);
      chk({tag, "_wr_addr"}, wr_addr, a);
      chk({tag, "_wr_data"}, wr_data, d);
      chk({tag, "_frame_done"}, frame_done, fd);
      $display("write %s: addr=%0d data=%08h frame_done=%0b", tag, wr_addr, wr_data, frame_done);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 8'h00);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_word;

      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      @(negedge clk);
      step(1'b0, 8'h00);
      chk_zero("reset");
      rst = 1'b0;

      // Single word 0x11223344
      step(1'b1, 8'h11);
      chk("s1_busy_after_first", busy, 1);
      chk("s1_no_wr_b1", wr_en, 0);
      step(1'b1, 8'h22);
      step(1'b1, 8'h33);
      chk("s1_no_wr_b3", wr_en, 0);
      step(1'b1, 8'h44);
      chk_write("s1", 2'd0, 32'h11223344, 1'b0);
      step(1'b0, 8'h00);
      chk("s1_wr_en_pulse", wr_en, 0);
      chk("s1_hold_data", wr_data, 32'h11223344);

      // Full frame, back-to-back bytes 0x00..0x0F
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, i[7:0]);
         if (i % 4 == 3) begin
            exp_word = {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)};
            chk_write("s2", 2'(i / 4), exp_word, (i == 15));
         end else begin
            chk("s2_no_wr", wr_en, 0);
         end
         chk("s2_busy", busy, (i != 15));
      end
      step(1'b0, 8'h00);
      chk("s2_idle_wr_en", wr_en, 0);
      chk("s2_idle_frame_done", frame_done, 0);
      chk("s2_idle_busy", busy, 0);
      chk("s2_hold_addr", wr_addr, 2'd3);
      chk("s2_hold_data", wr_data, 32'h0C0D0E0F);
      step(1'b1, 8'h55);
      step(1'b1, 8'h56);
      step(1'b1, 8'h57);
      step(1'b1, 8'h58);
      chk_write("s2_next_frame", 2'd0, 32'h55565758, 1'b0);

      // Byte arriving in the wr_en cycle starts the next word
      do_reset();
      step(1'b1, 8'h01);
      step(1'b1, 8'h02);
      step(1'b1, 8'h03);
      step(1'b1, 8'h04);
      chk_write("s3_w0", 2'd0, 32'h01020304, 1'b0);
      step(1'b1, 8'hAA);
      chk("s3_no_wr", wr_en, 0);
      step(1'b1, 8'hBB);
      step(1'b1, 8'hCC);
      step(1'b1, 8'hDD);
      chk_write("s3_w1", 2'd1, 32'hAABBCCDD, 1'b0);

      // Six bytes then 20 idle cycles
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, i[7:0]);
         if (i == 4) chk_write("s4_w0", 2'd0, 32'h01020304, 1'b0);
      end
`ifdef UART_FRAME_WRITER_TIMEOUT_EN
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 8'h00);
         chk("s4_timeout_err", timeout_err, (k == 20));
         chk("s4_busy", busy, (k < 20));
         chk("s4_no_partial_wr", wr_en, 0);
      end
      step(1'b0, 8'h00);
      chk("s4_timeout_pulse", timeout_err, 0);
      step(1'b1, 8'hA0);
      step(1'b1, 8'hA1);
      step(1'b1, 8'hA2);
      step(1'b1, 8'hA3);
      chk_write("s4_resync", 2'd0, 32'hA0A1A2A3, 1'b0);
`else
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 8'h00);
         chk("s4_timeout_err", timeout_err, 0);
         chk("s4_busy", busy, 1);
         chk("s4_no_wr", wr_en, 0);
      end
      step(1'b1, 8'h07);
      step(1'b1, 8'h08);
      chk_write("s4_complete", 2'd1, 32'h05060708, 1'b0);
`endif

      // Mid-frame reset discards the partial word
      step(1'b1, 8'hE1);
      step(1'b1, 8'hE2);
      rst = 1'b1;
      step(1'b1, 8'hE3);
      chk_zero("s5_in_reset");
      rst = 1'b0;
      step(1'b1, 8'hC1);
      chk("s5_no_wr_c1", wr_en, 0);
      step(1'b1, 8'hC2);
      step(1'b1, 8'hC3);
      chk("s5_no_wr_c3", wr_en, 0);
      step(1'b1, 8'hC4);
      chk_write("s5_after_reset", 2'd0, 32'hC1C2C3C4, 1'b0);
      step(1'b0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
